// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures each byte handed over by the uart core into a circular FIFO and acks it.
// Define UART_RX_FIFO_FWFT_EN for a first-word fall-through read port; default is a registered read.

module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_50m,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic [7:0]            rx_din,
   output logic                  rdy_clr,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  ovr_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  rdy_clr_q, rdy_clr_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  overrun_q, overrun_d;

   logic                  capture;
   logic                  wr_ok;
   logic                  wr_drop;
   logic                  rd_ok;

   logic [7:0]            mem [DEPTH];

   // Capture handshake: one accepted rdy assertion per IDLE->ACK->WAIT round trip.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (rdy) begin
               capture = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = WAIT;
         WAIT:    if (!rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rdy_clr_d = (state_d == ACK);
   end

   always_comb begin
      wr_ok     = capture && !full_q;
      wr_drop   = capture && full_q;
      rd_ok     = rd_en && !empty_q;

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Flags are derived from the next count so they leave the flops glitch-free.
      empty_d = (count_d == '0);
      full_d  = (count_d == COUNT_FULL);

      if (ovr_clr) overrun_d = 1'b0;
      if (wr_drop) overrun_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rdy_clr_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rdy_clr_q <= rdy_clr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         overrun_q <= overrun_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; entries are don't-care until written, and this keeps it mappable to RAM.
   always_ff @(posedge clk_50m) begin
      if (wr_ok) mem[wr_ptr_q] <= rx_din;
   end

`ifdef UART_RX_FIFO_FWFT_EN
   assign rd_data = mem[rd_ptr_q];
`else
   logic [7:0] rd_data_q, rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_ok) rd_data_d = mem[rd_ptr_q];
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) rd_data_q <= 8'h00;
      else     rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
`endif

   assign rdy_clr = rdy_clr_q;
   assign empty   = empty_q;
   assign full    = full_q;
   assign count   = count_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.

module tb_uart_rx_fifo;

   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic                clk_50m;
   logic                rst;
   logic                rdy;
   logic [7:0]          rx_din;
   logic                rdy_clr;
   logic                rd_en;
   logic [7:0]          rd_data;
   logic                empty;
   logic                full;
   logic [DEPTH_LOG2:0] count;
   logic                overrun;
   logic                ovr_clr;

   int n_checks = 0;
   int n_errors = 0;
   int pulses   = 0;

   // Model state: the FIFO is a queue; the handshake is "armed" until a byte is taken,
   // then ignores one edge and re-arms once rdy is seen low.
   logic [7:0] mq[$];
   bit         m_armed   = 1'b1;
   bit         m_hold    = 1'b0;
   bit         m_ovr     = 1'b0;
   bit         m_rdy_clr = 1'b0;
   logic [7:0] m_rd_data = 8'h00;
   int         m_sz;
   bit         m_take;

   uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk_50m (clk_50m),
      .rst     (rst),
      .rdy     (rdy),
      .rx_din  (rx_din),
      .rdy_clr (rdy_clr),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun),
      .ovr_clr (ovr_clr)
   );

   initial begin
      clk_50m = 1'b0;
      forever #10 clk_50m = ~clk_50m;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_50m or posedge rst);
         if (rst) begin
            mq.delete();
            m_armed   = 1'b1;
            m_hold    = 1'b0;
            m_ovr     = 1'b0;
            m_rdy_clr = 1'b0;
            m_rd_data = 8'h00;
         end else begin
            m_sz      = mq.size();
            m_take    = m_armed && rdy;
            m_rdy_clr = m_take;
            if (m_take) begin
               m_armed = 1'b0;
               m_hold  = 1'b1;
            end else if (m_hold) begin
               m_hold = 1'b0;
            end else if (!m_armed && !rdy) begin
               m_armed = 1'b1;
            end
            if (rd_en && m_sz != 0) m_rd_data = mq.pop_front();
            if (m_take && m_sz == DEPTH) m_ovr = 1'b1;
            else if (ovr_clr)            m_ovr = 1'b0;
            if (m_take && m_sz < DEPTH)  mq.push_back(rx_din);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_50m);
         if (rdy_clr === 1'b1) pulses++;
         if (rst === 1'b0) begin
            check("m_rdy_clr", 32'(rdy_clr), 32'(m_rdy_clr));
            check("m_count",   32'(count),   mq.size());
            check("m_empty",   32'(empty),   32'(mq.size() == 0));
            check("m_full",    32'(full),    32'(mq.size() == DEPTH));
            check("m_overrun", 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_FIFO_FWFT_EN
            if (mq.size() != 0) check("m_rd_data", 32'(rd_data), 32'(mq[0]));
`else
            check("m_rd_data", 32'(rd_data), 32'(m_rd_data));
`endif
         end
      end
   end

   task automatic send_byte(input logic [7:0] v);
      bit seen;
      seen = 1'b0;
      @(negedge clk_50m);
      rdy    = 1'b1;
      rx_din = v;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk_50m);
         if (rdy_clr === 1'b1) seen = 1'b1;
      end
      rdy = 1'b0;
      check("ack_seen", 32'(seen), 32'd1);
      repeat (2) @(negedge clk_50m);
   endtask

   task automatic pop(output logic [7:0] v);
      @(negedge clk_50m);
      rd_en = 1'b1;
`ifdef UART_RX_FIFO_FWFT_EN
      v = rd_data;
`endif
      @(negedge clk_50m);
      rd_en = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
      v = rd_data;
`endif
   endtask

   initial begin
      int         p0;
      logic [7:0] b;
      logic [7:0] v;

      rst = 1'b1; rdy = 1'b0; rx_din = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
      repeat (3) @(negedge clk_50m);
      rst = 1'b0;
      @(negedge clk_50m);
      check("rst_rdy_clr", 32'(rdy_clr), 32'd0);
      check("rst_empty",   32'(empty),   32'd1);
      check("rst_full",    32'(full),    32'd0);
      check("rst_count",   32'(count),   32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
`ifndef UART_RX_FIFO_FWFT_EN
      check("rst_rd_data", 32'(rd_data), 32'h00);
`endif

      p0 = pulses;
      send_byte(8'hA5);
      check("one_pulses", 32'(pulses - p0), 32'd1);
      check("one_count",  32'(count),       32'd1);
      check("one_empty",  32'(empty),       32'd0);
      pop(b);
      check("one_data",   32'(b),           32'hA5);
      check("one_drained", 32'(empty),      32'd1);

      p0 = pulses;
      @(negedge clk_50m);
      rdy = 1'b1; rx_din = 8'h3C;
      repeat (10) @(negedge clk_50m);
      rdy = 1'b0;
      repeat (3) @(negedge clk_50m);
      check("sticky_pulses", 32'(pulses - p0), 32'd1);
      check("sticky_count",  32'(count),       32'd1);
      pop(b);
      check("sticky_data",   32'(b),           32'h3C);

      for (int i = 0; i < DEPTH; i++) begin
         v = 8'(i);
         send_byte(v);
      end
      check("fill_full",  32'(full),  32'd1);
      check("fill_count", 32'(count), 32'd16);
      send_byte(8'hFF);
      check("ovr_set",    32'(overrun), 32'd1);
      check("ovr_count",  32'(count),   32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         pop(b);
         check("drain_data", 32'(b), i);
      end
      check("drain_empty", 32'(empty), 32'd1);
      @(negedge clk_50m);
      ovr_clr = 1'b1;
      @(negedge clk_50m);
      ovr_clr = 1'b0;
      check("ovr_clear", 32'(overrun), 32'd0);

      for (int i = 0; i < DEPTH; i++) begin
         v = 8'(8'h10 + i);
         send_byte(v);
      end
      @(negedge clk_50m);
      rdy = 1'b1; rx_din = 8'hEE; rd_en = 1'b1;
      @(negedge clk_50m);
      rd_en = 1'b0; rdy = 1'b0;
      check("simf_rdy_clr", 32'(rdy_clr), 32'd1);
      check("simf_count",   32'(count),   32'd15);
      check("simf_overrun", 32'(overrun), 32'd1);
      repeat (2) @(negedge clk_50m);

      @(negedge clk_50m);
      rdy = 1'b1; rx_din = 8'h55;
      @(negedge clk_50m);
      check("ack_rdy_clr", 32'(rdy_clr), 32'd1);
      check("ack_count",   32'(count),   32'd16);
      #1;
      rst = 1'b1; rdy = 1'b0;
      #1;
      check("arst_rdy_clr", 32'(rdy_clr), 32'd0);
      check("arst_count",   32'(count),   32'd0);
      check("arst_overrun", 32'(overrun), 32'd0);
      check("arst_empty",   32'(empty),   32'd1);
      repeat (2) @(negedge clk_50m);
      rst = 1'b0;

      @(negedge clk_50m);
      rdy = 1'b1; rx_din = 8'h77; rd_en = 1'b1;
      @(negedge clk_50m);
      rd_en = 1'b0; rdy = 1'b0;
      check("sime_count", 32'(count), 32'd1);
      check("sime_empty", 32'(empty), 32'd0);
      repeat (2) @(negedge clk_50m);
      pop(b);
      check("sime_data",  32'(b),     32'h77);

      for (int i = 0; i < 40; i++) begin
         v = 8'(i);
         send_byte(v);
         check("wrap_count", 32'(count), 32'd1);
         pop(b);
         check("wrap_data",  32'(b),     i);
      end
      check("wrap_empty", 32'(empty), 32'd1);

      repeat (2) @(negedge clk_50m);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
